// File: rtl/boot_pkg.sv
// Shared types for the UART boot loader: FSM states, frame header, receive buffer.
package boot_pkg;
  localparam logic [7:0] BOOT_SYNC = 8'hA5;

  typedef enum logic [3:0] {
    IDLE, COUNT, DATA_HI, DATA_LO, WR_SETUP, WR_PULSE, WR_HOLD, CHECK, DONE
  } boot_state_t;

  // One received byte plus whether its stop bit was bad.
  typedef struct packed {
    logic       vld;
    logic       err;
    logic [7:0] data;
  } rx_buf_t;
endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit start re-check, one-cycle result pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err
);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  localparam int CW = $clog2(CLKS_PER_BIT);

  // [1:0] synchronize the line, [2] keeps the previous synchronized level for edge detect
  logic [2:0]    rx_sync;
  logic [CW-1:0] baud;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  rx_state_t     st, nst;
  logic          rxs, baud_tick, half_tick;

  assign rxs       = rx_sync[1];
  assign baud_tick = (baud == CW'(CLKS_PER_BIT - 1));
  assign half_tick = (baud == CW'(CLKS_PER_BIT / 2 - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) st <= R_IDLE;
    else          st <= nst;
  end

  always_comb begin
    nst = st;
    case (st)
      R_IDLE:  if (rx_sync[2] && !rxs) nst = R_START;
      R_START: if (half_tick) nst = rxs ? R_IDLE : R_DATA;
      R_DATA:  if (baud_tick && bitn == 3'd7) nst = R_STOP;
      R_STOP:  if (baud_tick) nst = R_IDLE;
      default: nst = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_sync      <= 3'b111;
      baud         <= '0;
      bitn         <= '0;
      shreg        <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_sync      <= {rx_sync[1:0], rx};
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      // baud restarts on every state change so each phase is timed from its own entry
      if (st != nst || baud_tick) baud <= '0;
      else                        baud <= baud + 1'b1;
      if (st == R_START) bitn <= '0;
      if (st == R_DATA && baud_tick) begin
        shreg <= {rxs, shreg[7:1]};
        bitn  <= bitn + 1'b1;
      end
      if (st == R_STOP && baud_tick) begin
        rx_byte      <= shreg;
        rx_valid     <= rxs;
        rx_frame_err <= !rxs;
      end
    end
  end
endmodule

// File: rtl/uart_boot_loader.sv
// Loads a UART-framed image into external SRAM with the processor held in reset,
// then hands the bus over and releases the processor.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         ADDR_WIDTH   = 8,
  parameter int         DATA_WIDTH   = 16,
  parameter logic [7:0] SYNC_BYTE    = BOOT_SYNC
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx,
  output logic                  mem_ce_n,
  output logic                  mem_oe_n,
  output logic                  mem_we_n,
  output logic [ADDR_WIDTH-1:0] mem_adr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  bus_own,
  output logic                  proc_reset,
  output logic                  done,
  output logic                  error
);
  logic [7:0]            rx_byte;
  logic                  rx_valid, rx_frame_err;
  rx_buf_t               buf_q;
  boot_state_t           state, nstate;
  logic [ADDR_WIDTH-1:0] adr;
  logic [8:0]            n_words;
  logic [7:0]            hi_q, lo_q, csum;
  logic                  error_q, proc_reset_q, take, last_word, drive;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .reset_n(reset_n), .rx(rx),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err)
  );

  assign last_word = (9'(adr) == n_words - 9'd1);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= nstate;
  end

  always_comb begin
    nstate = state;
    take   = 1'b0;
    case (state)
      IDLE: if (buf_q.vld) begin
        take = 1'b1;
        if (!buf_q.err && buf_q.data == SYNC_BYTE) nstate = COUNT;
      end
      COUNT, DATA_HI, DATA_LO: if (buf_q.vld) begin
        take = 1'b1;
        if (buf_q.err)             nstate = IDLE;
        else if (state == COUNT)   nstate = DATA_HI;
        else if (state == DATA_HI) nstate = DATA_LO;
        else                       nstate = WR_SETUP;
      end
      WR_SETUP: nstate = WR_PULSE;
      WR_PULSE: nstate = WR_HOLD;
      WR_HOLD:  nstate = last_word ? CHECK : DATA_HI;
      CHECK: if (buf_q.vld) begin
        take   = 1'b1;
        nstate = (!buf_q.err && buf_q.data == csum) ? DONE : IDLE;
      end
      DONE:    take = buf_q.vld;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buf_q        <= '0;
      adr          <= '0;
      n_words      <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      csum         <= '0;
      error_q      <= 1'b0;
      proc_reset_q <= 1'b1;
    end else begin
      // proc_reset trails bus_own by one cycle so the processor never sees a contended bus
      proc_reset_q <= bus_own;
      if (rx_valid || rx_frame_err) buf_q <= '{vld: 1'b1, err: rx_frame_err, data: rx_byte};
      else if (take)                buf_q.vld <= 1'b0;
      if (take) begin
        case (state)
          IDLE: if (!buf_q.err && buf_q.data == SYNC_BYTE) begin
            error_q <= 1'b0;
            csum    <= '0;
            adr     <= '0;
          end
          COUNT: begin
            if (buf_q.err) error_q <= 1'b1;
            else           n_words <= (buf_q.data == 8'd0) ? 9'd256 : {1'b0, buf_q.data};
          end
          DATA_HI, DATA_LO: begin
            if (buf_q.err) error_q <= 1'b1;
            else begin
              if (state == DATA_HI) hi_q <= buf_q.data;
              else                  lo_q <= buf_q.data;
              csum <= csum + buf_q.data;
            end
          end
          CHECK: if (buf_q.err || buf_q.data != csum) error_q <= 1'b1;
          default: ;
        endcase
      end
      if (state == WR_HOLD) adr <= adr + 1'b1;
    end
  end

  assign drive      = (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);
  assign mem_ce_n   = !drive;
  assign mem_we_n   = (state != WR_PULSE);
  assign mem_oe_n   = 1'b1;
  assign mem_adr    = adr;
  assign mem_data   = drive ? DATA_WIDTH'({hi_q, lo_q}) : {DATA_WIDTH{1'bz}};
  assign bus_own    = (state != DONE);
  assign done       = (state == DONE);
  assign error      = error_q;
  assign proc_reset = proc_reset_q;
endmodule
